// File: rtl/yolo_pkg.sv
// Shared types and constants for the conv/pool datapath: lane geometry, FSM states, lane slicing.
package yolo_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned LANES        = 4;
   localparam int unsigned WORD_W       = DATA_W * LANES;
   localparam int unsigned MAX_IMG_SIZE = 416;
   localparam int unsigned COL_W        = 9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Signed view of lane k of a packed word
   function automatic logic signed [DATA_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                         input int unsigned       k);
      return word[k*DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// Config + streaming bus between the convolution stage and the 2x2 max-pool stage.
interface maxpool_2x2_stream_if;
   import yolo_pkg::*;

   logic              i_cfg_valid;
   logic [COL_W-1:0]  i_cfg_width;
   logic              i_data_en;
   logic [WORD_W-1:0] i_data;
   logic              i_last;
   logic              o_data_en;
   logic [WORD_W-1:0] o_data;
   logic              o_done;

   modport master (
      output i_cfg_valid, i_cfg_width, i_data_en, i_data, i_last,
      input  o_data_en, o_data, o_done
   );

   modport slave (
      input  i_cfg_valid, i_cfg_width, i_data_en, i_data, i_last,
      output o_data_en, o_data, o_done
   );

endinterface

// File: rtl/pool_lane_max.sv
// Combinational per-lane signed max of two packed words.
module pool_lane_max
   import yolo_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] max_c
);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [DATA_W-1:0] la;
      logic signed [DATA_W-1:0] lb;
      assign la = lane_sel(a, k);
      assign lb = lane_sel(b, k);
      assign max_c[k*DATA_W +: DATA_W] = (la >= lb) ? la : lb;
   end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 per-lane max-pool over a raster stream, one output word per window.
// Optional leaky-ReLU on the input lanes when LEAKY_RELU_EN is defined.
module maxpool_2x2_stream #(
   parameter int unsigned DATA_W    = yolo_pkg::DATA_W,
   parameter int unsigned LANES     = yolo_pkg::LANES,
   parameter int unsigned MAX_WIDTH = yolo_pkg::MAX_IMG_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   maxpool_2x2_stream_if.slave  bus
);
   import yolo_pkg::*;

   localparam int unsigned      WORD_BITS = DATA_W * LANES;
   localparam int unsigned      LB_DEPTH  = MAX_WIDTH / 2;
   localparam int unsigned      LB_AW     = COL_W - 1;
   localparam logic [COL_W-1:0] MAX_W     = COL_W'(MAX_WIDTH);

   state_t               state_q, state_d;
   logic [COL_W-1:0]     width_q;
   logic [COL_W-1:0]     col_q;
   logic                 row_odd_q;
   logic [WORD_BITS-1:0] h_reg;
   logic [WORD_BITS-1:0] line_buf [LB_DEPTH];

   logic                 o_data_en_q;
   logic [WORD_BITS-1:0] o_data_q;
   logic                 o_done_q;

   logic                 accept, cfg_load, out_en_d, done_d, col_wrap, cfg_ok;
   logic [LB_AW-1:0]     lb_idx;
   logic [WORD_BITS-1:0] x_act, hmax_c, vmax_c, lb_rd;

`ifdef LEAKY_RELU_EN
   // Negative lanes scaled by 1/8 via arithmetic shift
   for (genvar k = 0; k < LANES; k++) begin : g_leaky
      logic signed [DATA_W-1:0] lane;
      assign lane = bus.i_data[k*DATA_W +: DATA_W];
      assign x_act[k*DATA_W +: DATA_W] = lane[DATA_W-1] ? (lane >>> 3) : lane;
   end
`else
   assign x_act = bus.i_data;
`endif

   assign cfg_ok   = (bus.i_cfg_width >= COL_W'(2)) && (bus.i_cfg_width <= MAX_W);
   assign col_wrap = (col_q == width_q - COL_W'(1));
   assign lb_idx   = col_q[LB_AW:1];
   assign lb_rd    = line_buf[lb_idx];

   pool_lane_max u_hmax (.a(h_reg), .b(x_act),  .max_c(hmax_c));
   pool_lane_max u_vmax (.a(lb_rd), .b(hmax_c), .max_c(vmax_c));

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      cfg_load = 1'b0;
      out_en_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_cfg_valid && cfg_ok) begin
               cfg_load = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            accept   = bus.i_data_en;
            out_en_d = bus.i_data_en && col_q[0] && row_odd_q;
            if (bus.i_data_en && bus.i_last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         width_q     <= '0;
         col_q       <= '0;
         row_odd_q   <= 1'b0;
         h_reg       <= '0;
         o_data_en_q <= 1'b0;
         o_data_q    <= '0;
         o_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         o_data_en_q <= out_en_d;
         o_data_q    <= out_en_d ? vmax_c : '0;
         o_done_q    <= done_d;
         if (cfg_load) begin
            width_q   <= bus.i_cfg_width;
            col_q     <= '0;
            row_odd_q <= 1'b0;
         end else if (accept) begin
            if (col_wrap) begin
               col_q     <= '0;
               row_odd_q <= ~row_odd_q;
            end else begin
               col_q <= col_q + COL_W'(1);
            end
            if (!col_q[0]) h_reg <= x_act;
         end
      end
   end

   // Even rows fill the buffer before odd rows read it, so no clear is needed
   always_ff @(posedge clk) begin
      if (accept && col_q[0] && !row_odd_q) line_buf[lb_idx] <= hmax_c;
   end

   assign bus.o_data_en = o_data_en_q;
   assign bus.o_data    = o_data_q;
   assign bus.o_done    = o_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream: frame shapes, negatives, gaps, reset, bad configs.
module tb_maxpool_2x2_stream;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   maxpool_2x2_stream_if bus ();

   maxpool_2x2_stream dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input, then check the registered outputs it produces
   task automatic cyc(input logic en, input logic [63:0] d, input logic last,
                      input logic exp_en, input logic [63:0] exp_d, input logic exp_done,
                      input string tag);
      bus.i_data_en = en;
      bus.i_data    = d;
      bus.i_last    = last;
      @(posedge clk);
      #1;
      chk({tag, ".en"},   64'(bus.o_data_en), 64'(exp_en));
      chk({tag, ".data"}, bus.o_data,         exp_d);
      chk({tag, ".done"}, 64'(bus.o_done),    64'(exp_done));
      @(negedge clk);
   endtask

   task automatic cfg(input logic [8:0] w, input string tag);
      bus.i_cfg_valid = 1'b1;
      bus.i_cfg_width = w;
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, tag);
      bus.i_cfg_valid = 1'b0;
   endtask

   initial begin
      logic        e;
      logic [63:0] w;

      rst             = 1'b1;
      bus.i_cfg_valid = 1'b0;
      bus.i_cfg_width = '0;
      bus.i_data_en   = 1'b0;
      bus.i_data      = '0;
      bus.i_last      = 1'b0;
      @(negedge clk);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, "reset");
      rst = 1'b0;

      // W=4, 4x4, lane0 = raster index
      cfg(9'd4, "s1.cfg");
      for (int n = 0; n < 16; n++) begin
         e = (n == 5) || (n == 7) || (n == 13) || (n == 15);
         cyc(1'b1, 64'(n), n == 15, e, e ? 64'(n) : 64'd0, n == 15, "s1");
      end
      cyc(1'b1, 64'h1234, 1'b0, 1'b0, 64'd0, 1'b0, "s1.idle_data");

      // W=5, 5x5, all lanes = raster index; col 4 and row 4 dropped
      cfg(9'd5, "s2.cfg");
      for (int n = 0; n < 25; n++) begin
         e = (n == 6) || (n == 8) || (n == 16) || (n == 18);
         w = {4{16'(n)}};
         cyc(1'b1, w, n == 24, e, e ? w : 64'd0, n == 24, "s2");
      end

      // W=2, negative lane1 values
      cfg(9'd2, "s3.cfg");
      cyc(1'b1, 64'h0000_0000_FFFC_0000, 1'b0, 1'b0, 64'd0, 1'b0, "s3.w0");
      cyc(1'b1, 64'h0000_0000_FFF8_0000, 1'b0, 1'b0, 64'd0, 1'b0, "s3.w1");
      cyc(1'b1, 64'h0000_0000_FFFE_0000, 1'b0, 1'b0, 64'd0, 1'b0, "s3.w2");
`ifdef LEAKY_RELU_EN
      cyc(1'b1, 64'h0000_0000_FFF0_0000, 1'b1, 1'b1, 64'h0000_0000_FFFF_0000, 1'b1, "s3.w3");
`else
      cyc(1'b1, 64'h0000_0000_FFF0_0000, 1'b1, 1'b1, 64'h0000_0000_FFFE_0000, 1'b1, "s3.w3");
`endif

      // W=4 with a gap after every word; i_last during gaps must be ignored
      cfg(9'd4, "s4.cfg");
      for (int n = 0; n < 16; n++) begin
         e = (n == 5) || (n == 7) || (n == 13) || (n == 15);
         cyc(1'b1, 64'(n), n == 15, e, e ? 64'(n) : 64'd0, n == 15, "s4");
         cyc(1'b0, 64'hDEAD, n != 15, 1'b0, 64'd0, 1'b0, "s4.gap");
      end

      // Reset mid-frame, then a fresh W=2 frame
      cfg(9'd4, "s5.cfg");
      for (int n = 0; n < 6; n++) begin
         cyc(1'b1, 64'(n), 1'b0, n == 5, n == 5 ? 64'd5 : 64'd0, 1'b0, "s5");
      end
      rst = 1'b1;
      cyc(1'b1, 64'd6, 1'b0, 1'b0, 64'd0, 1'b0, "s5.rst");
      rst = 1'b0;
      cfg(9'd2, "s5.cfg2");
      cyc(1'b1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b0, "s5.w1");
      cyc(1'b1, 64'd2, 1'b0, 1'b0, 64'd0, 1'b0, "s5.w2");
      cyc(1'b1, 64'd3, 1'b0, 1'b0, 64'd0, 1'b0, "s5.w3");
      cyc(1'b1, 64'd4, 1'b1, 1'b1, 64'd4, 1'b1, "s5.w4");

      // Out-of-range widths leave the block idle
      cfg(9'd1, "s6.cfg1");
      for (int n = 0; n < 6; n++) begin
         cyc(1'b1, 64'(n + 50), n == 5, 1'b0, 64'd0, 1'b0, "s6.w1");
      end
      cfg(9'd417, "s6.cfg417");
      for (int n = 0; n < 6; n++) begin
         cyc(1'b1, 64'(n + 70), n == 5, 1'b0, 64'd0, 1'b0, "s6.w417");
      end

      // Maximum width, two rows: 208 outputs, last one with o_done
      cfg(9'd416, "s7.cfg");
      for (int n = 0; n < 832; n++) begin
         e = (n >= 416) && (n % 2 == 1);
         cyc(1'b1, 64'(n), n == 831, e, e ? 64'(n) : 64'd0, n == 831, "s7");
      end
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, "s7.after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
